// File: rtl/tick_wdog_pkg.sv
// Shared types and default timing window for the tick watchdog.
// Optional sticky-fault behaviour is selected with TICK_WDOG_STICKY_EN.
package tick_wdog_pkg;

    localparam int DEF_MIN_GAP = 25000;
    localparam int DEF_MAX_GAP = 25002;
    localparam int DEF_CNT_W   = 15;
    localparam int DEF_TCNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        EARLY    = 2'b01,
        LATE     = 2'b10,
        UPSTREAM = 2'b11
    } cause_e;

endpackage

// File: rtl/sat_gap_counter.sv
// Cycles-since-last-tick counter: loads 1 on a tick, otherwise counts up and
// sticks at all-ones so a long silence never wraps into a legal-looking gap.
module sat_gap_counter #(
    parameter int CNT_W = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tick_watchdog.sv
// Checks that a periodic tick arrives within [MIN_GAP, MAX_GAP] cycles of the previous one.
// Define TICK_WDOG_STICKY_EN to hold FAULT (and its first cause) until reset.
module tick_watchdog
    import tick_wdog_pkg::*;
#(
    parameter int MIN_GAP = DEF_MIN_GAP,
    parameter int MAX_GAP = DEF_MAX_GAP,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TCNT_W  = DEF_TCNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              err_in,
    output logic              ok,
    output logic              fault,
    output logic [1:0]        cause,
    output logic [TCNT_W-1:0] tick_cnt
);

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_GAP);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_GAP);

    logic [CNT_W-1:0]  cnt;
    state_e            state_d, state_q;
    cause_e            cause_d, cause_q;
    logic              ok_d, ok_q;
    logic              fault_d, fault_q;
    logic [TCNT_W-1:0] tick_cnt_d, tick_cnt_q;
    logic              good;

    sat_gap_counter #(.CNT_W(CNT_W)) u_gap (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .cnt  (cnt)
    );

    // cnt still holds the gap ending at this cycle; decisions use that pre-edge value.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        good    = 1'b0;
        case (state_q)
            IDLE: begin
                if (err_in) begin
                    state_d = FAULT;
                    cause_d = UPSTREAM;
                end else if (tick) begin
                    state_d = RUN;
                    good    = 1'b1;
                end else if (cnt >= MAX_C) begin
                    state_d = FAULT;
                    cause_d = LATE;
                end
            end
            RUN: begin
                if (err_in) begin
                    state_d = FAULT;
                    cause_d = UPSTREAM;
                end else if (tick && (cnt < MIN_C)) begin
                    state_d = FAULT;
                    cause_d = EARLY;
                end else if (tick ? (cnt > MAX_C) : (cnt >= MAX_C)) begin
                    state_d = FAULT;
                    cause_d = LATE;
                end else if (tick) begin
                    good = 1'b1;
                end
            end
            FAULT: begin
`ifndef TICK_WDOG_STICKY_EN
                if (err_in) begin
                    cause_d = UPSTREAM;
                end else if (tick) begin
                    state_d = RUN;
                    cause_d = NONE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                cause_d = NONE;
            end
        endcase

        tick_cnt_d = tick_cnt_q;
        if (good && (tick_cnt_q != '1)) begin
            tick_cnt_d = tick_cnt_q + TCNT_W'(1);
        end

        ok_d    = (state_d == RUN);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cause_q    <= NONE;
            ok_q       <= 1'b0;
            fault_q    <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            ok_q       <= ok_d;
            fault_q    <= fault_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign ok       = ok_q;
    assign fault    = fault_q;
    assign cause    = cause_q;
    assign tick_cnt = tick_cnt_q;

endmodule

// File: tb/tb_tick_watchdog.sv
// Directed bench for tick_watchdog with a 4..6 cycle window and 4-bit counters.
module tb_tick_watchdog;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       err_in;
    logic       ok;
    logic       fault;
    logic [1:0] cause;
    logic [3:0] tick_cnt;

    int total = 0;
    int bad   = 0;

    tick_watchdog #(
        .MIN_GAP (4),
        .MAX_GAP (6),
        .CNT_W   (4),
        .TCNT_W  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .err_in   (err_in),
        .ok       (ok),
        .fault    (fault),
        .cause    (cause),
        .tick_cnt (tick_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic t, input logic e);
        tick   = t;
        err_in = e;
        @(posedge clk);
        #1;
        tick   = 1'b0;
        err_in = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        #3;
        rst = 1'b1;
    endtask

    task automatic check_outs(input string tag, input logic e_ok, input logic e_fault,
                              input logic [1:0] e_cause, input logic [3:0] e_tc);
        check({tag, ".ok"}, 32'(ok), 32'(e_ok));
        check({tag, ".fault"}, 32'(fault), 32'(e_fault));
        check({tag, ".cause"}, 32'(cause), 32'(e_cause));
        check({tag, ".tick_cnt"}, 32'(tick_cnt), 32'(e_tc));
    endtask

    initial begin
        rst    = 1'b0;
        tick   = 1'b0;
        err_in = 1'b0;
        #2;
        check_outs("reset", 1'b0, 1'b0, 2'b00, 4'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Ticks every 5 cycles, 10 times.
        cyc(1'b1, 1'b0);
        check_outs("first_tick", 1'b1, 1'b0, 2'b00, 4'd1);
        for (int i = 0; i < 9; i++) begin
            repeat (4) begin
                cyc(1'b0, 1'b0);
                check("periodic_gap.fault", 32'(fault), 32'd0);
            end
            cyc(1'b1, 1'b0);
            check("periodic_tick.ok", 32'(ok), 32'd1);
        end
        check_outs("periodic_done", 1'b1, 1'b0, 2'b00, 4'd10);

        // Early tick: gap of 3.
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("pre_early.ok", 32'(ok), 32'd1);
        cyc(1'b1, 1'b0);
        check_outs("early", 1'b0, 1'b1, 2'b01, 4'd10);

        cyc(1'b0, 1'b1);
`ifdef TICK_WDOG_STICKY_EN
        check_outs("err_in_fault_sticky", 1'b0, 1'b1, 2'b01, 4'd10);
        cyc(1'b1, 1'b0);
        check_outs("recover_sticky", 1'b0, 1'b1, 2'b01, 4'd10);
`else
        check_outs("err_in_fault", 1'b0, 1'b1, 2'b11, 4'd10);
        cyc(1'b1, 1'b0);
        check_outs("recover", 1'b1, 1'b0, 2'b00, 4'd10);
`endif

        // Late in RUN: fault appears on the cycle after cnt reaches 6.
        reset_dut();
        cyc(1'b1, 1'b0);
        repeat (5) cyc(1'b0, 1'b0);
        check_outs("run_cnt6", 1'b1, 1'b0, 2'b00, 4'd1);
        cyc(1'b0, 1'b0);
        check_outs("run_late", 1'b0, 1'b1, 2'b10, 4'd1);
        cyc(1'b0, 1'b0);
        check_outs("run_late_hold", 1'b0, 1'b1, 2'b10, 4'd1);

        // Late in IDLE: counter starts at 0 after reset.
        reset_dut();
        repeat (6) cyc(1'b0, 1'b0);
        check_outs("idle_cnt6", 1'b0, 1'b0, 2'b00, 4'd0);
        cyc(1'b0, 1'b0);
        check_outs("idle_late", 1'b0, 1'b1, 2'b10, 4'd0);

        // Tick coinciding with err_in in RUN.
        reset_dut();
        cyc(1'b1, 1'b0);
        repeat (4) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        check_outs("tick_err", 1'b0, 1'b1, 2'b11, 4'd1);
        cyc(1'b1, 1'b0);
`ifdef TICK_WDOG_STICKY_EN
        check_outs("tick_err_after_sticky", 1'b0, 1'b1, 2'b11, 4'd1);
`else
        check_outs("tick_err_after", 1'b1, 1'b0, 2'b00, 4'd1);
`endif

        // 20 good ticks saturate the 4-bit counter.
        reset_dut();
        cyc(1'b1, 1'b0);
        for (int i = 1; i < 20; i++) begin
            repeat (4) cyc(1'b0, 1'b0);
            cyc(1'b1, 1'b0);
            if (i == 14) check("tc_at_15", 32'(tick_cnt), 32'd15);
        end
        check_outs("saturate", 1'b1, 1'b0, 2'b00, 4'd15);

        // Asynchronous reset from FAULT, then a fresh first tick.
        cyc(1'b0, 1'b1);
        check_outs("pre_async", 1'b0, 1'b1, 2'b11, 4'd15);
        #1;
        rst = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 1'b0, 2'b00, 4'd0);
        #2;
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check_outs("post_rst_idle", 1'b0, 1'b0, 2'b00, 4'd0);
        cyc(1'b1, 1'b0);
        check_outs("post_rst_tick", 1'b1, 1'b0, 2'b00, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tick_watchdog.md
TICK_WATCHDOG -- requirements
Module: tick_watchdog

Interface
REQ-001 SHALL have parameter MIN_GAP, default 25000: minimum legal cycles between consecutive ticks.
REQ-002 SHALL have parameter MAX_GAP, default 25002: maximum legal cycles between consecutive ticks; MAX_GAP >= MIN_GAP >= 2.
REQ-003 SHALL have parameter CNT_W, default 15: gap counter width; 2**CNT_W-1 >= MAX_GAP.
REQ-004 SHALL have parameter TCNT_W, default 16: good-tick counter width.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-low.
REQ-007 tick  input  1  one-cycle periodic pulse from the upstream delay stage (its sig).
REQ-008 err_in  input  1  upstream error flag (its err); level-sensitive.
REQ-009 ok  output  1  high while in RUN.
REQ-010 fault  output  1  high while in FAULT.
REQ-011 cause  output  2  fault cause: 00 none, 01 early, 10 late, 11 upstream error.
REQ-012 tick_cnt  output  TCNT_W  count of good ticks.

Function
REQ-013 Gap counter cnt SHALL load 1 on a tick cycle, else increment, saturating at 2**CNT_W-1; at a tick cycle cnt equals the gap since the previous tick.
REQ-014 FSM states SHALL be IDLE (waiting for first tick), RUN (periodic ticks within window) and FAULT.
REQ-015 Evaluation priority each cycle SHALL be: err_in, then early, then late, then good tick.
REQ-016 In any state, err_in=1 SHALL transition to FAULT with cause 11; a coincident tick is not counted.
REQ-017 IDLE: tick SHALL go to RUN without an early check; no tick and cnt >= MAX_GAP SHALL go to FAULT with cause 10.
REQ-018 RUN: tick with cnt < MIN_GAP SHALL go to FAULT with cause 01; tick with MIN_GAP <= cnt <= MAX_GAP is good and stays in RUN.
REQ-019 RUN: no tick and cnt >= MAX_GAP SHALL go to FAULT with cause 10, one cycle after the last legal tick slot.
REQ-020 tick_cnt SHALL increment by 1 on every good tick and on the IDLE-to-RUN tick, saturate at all-ones, and never clear except on reset.
REQ-021 ok, fault and cause SHALL be registered and reflect the decision made on the previous clock edge (one-cycle latency); ok and fault SHALL never both be high.
REQ-022 cause SHALL be 00 whenever fault is low.

Reset
REQ-023 While rst=0, state SHALL be IDLE, cnt=0, ok=0, fault=0, cause=00, tick_cnt=0, asynchronously.
REQ-024 Reset asserted mid-gap or in FAULT SHALL discard all history; the first tick after release is treated as an IDLE first tick.

Configuration
REQ-025 With TICK_WDOG_STICKY_EN defined, FAULT SHALL be held until reset; cause SHALL keep its first value.
REQ-026 Without TICK_WDOG_STICKY_EN, a tick with err_in=0 in FAULT SHALL return to RUN, clear cause to 00, reload cnt=1 and not increment tick_cnt; err_in=1 in FAULT SHALL update cause to 11.

Structure
REQ-027 Package tick_wdog_pkg SHALL hold the state enum (IDLE, RUN, FAULT), the cause enum (NONE, EARLY, LATE, UPSTREAM) and the default MIN_GAP/MAX_GAP constants.
REQ-028 Gap counting SHALL be a sub-module sat_gap_counter (load-1 on tick, saturating increment, width CNT_W).

Verification (MIN_GAP=4, MAX_GAP=6, CNT_W=4, TCNT_W=4)
REQ-029 Ticks every 5 cycles, 10 times -> ok=1 from cycle after first tick, fault=0 throughout, tick_cnt=10.
REQ-030 RUN, next tick 3 cycles after previous -> fault=1, cause=01 next cycle, tick_cnt unchanged.
REQ-031 RUN, no tick for 7 cycles -> fault=1, cause=10 one cycle after cnt reaches 6.
REQ-032 tick and err_in together in RUN -> fault=1, cause=11, tick_cnt unchanged; non-sticky build: subsequent tick with err_in=0 -> ok=1, cause=00; sticky build: fault stays 1.
REQ-033 20 good ticks -> tick_cnt saturates at 15.
REQ-034 rst pulled low between clock edges while in FAULT -> all outputs 0 immediately; after release, a tick 2 cycles later -> RUN, tick_cnt=1.
